// File: rtl/color_detector_pipe.sv
// color_detector_pipe: YCbCr->RGB with target-colour classification and per-frame hit count; optional bbox via COLOR_DET_BBOX_EN.
// Latency 3 cycles (e_pix sample -> out_valid); 1 pixel/cycle; no backpressure, input is never stalled.
module color_detector_pipe #(
  parameter int         DW     = 8,
  parameter int         THRESH = 70,
  parameter logic [1:0] MARK   = 2'b11,
  parameter int         CNT_W  = 20,
  parameter int         X_W    = 10,
  parameter int         Y_W    = 9
) (
  input  logic             PCLK,
  input  logic             reset,
  input  logic             e_pix,
  input  logic             sof,
  input  logic             eol,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    Y,
  input  logic [DW-1:0]    Cb,
  input  logic [DW-1:0]    Cr,
  output logic             out_valid,
  output logic             hit,
  output logic [DW-1:0]    Y_out,
  output logic [DW-1:0]    R_out,
  output logic [DW-1:0]    G_out,
  output logic [DW-1:0]    B_out,
  output logic [CNT_W-1:0] frame_hits,
  output logic             frame_done
`ifdef COLOR_DET_BBOX_EN
  ,
  output logic [X_W-1:0]   bbox_x_min,
  output logic [X_W-1:0]   bbox_x_max,
  output logic [Y_W-1:0]   bbox_y_min,
  output logic [Y_W-1:0]   bbox_y_max,
  output logic             bbox_valid
`endif
);

  localparam int PW  = DW + 12;
  localparam int DDW = DW + 2;
  localparam logic signed [DW:0]    CHROMA_OFS = (DW+1)'(1 << (DW-1));
  localparam logic signed [PW-1:0]  K_R_CR     = PW'(1436);
  localparam logic signed [PW-1:0]  K_G_CB     = PW'(352);
  localparam logic signed [PW-1:0]  K_G_CR     = PW'(731);
  localparam logic signed [PW-1:0]  K_B_CB     = PW'(1815);
  localparam logic signed [PW-1:0]  PIX_MAX    = PW'((1 << DW) - 1);
  localparam logic signed [DDW-1:0] MARGIN     = DDW'(THRESH);

  logic                 v1, v2, v3, sof1, sof2, sof3;
  logic [1:0]           mode1, mode2, mode3;
  logic [DW-1:0]        y1, y2, y3;
  logic signed [DW:0]   cb1, cr1;
  logic signed [PW-1:0] p_r_cr, p_g_cb, p_g_cr, p_b_cb;
  logic signed [PW-1:0] r3, g3, b3;
  logic [DW-1:0]        r_c, g_c, b_c;
  logic                 match, hit_nxt;
  logic [CNT_W-1:0]     hit_cnt;

  always_ff @(posedge PCLK) begin
    if (reset) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      sof1 <= 1'b0;
      sof2 <= 1'b0;
      sof3 <= 1'b0;
    end else begin
      v1   <= e_pix;
      v2   <= v1;
      v3   <= v2;
      sof1 <= sof;
      sof2 <= sof1;
      sof3 <= sof2;
    end
  end

  // Datapath carries no reset; the valid bits above decide what is real.
  always_ff @(posedge PCLK) begin
    y1     <= Y;
    mode1  <= mode;
    cb1    <= $signed({1'b0, Cb}) - CHROMA_OFS;
    cr1    <= $signed({1'b0, Cr}) - CHROMA_OFS;
    y2     <= y1;
    mode2  <= mode1;
    p_r_cr <= (PW'(cr1) * K_R_CR) >>> 10;
    p_g_cb <= (PW'(cb1) * K_G_CB) >>> 10;
    p_g_cr <= (PW'(cr1) * K_G_CR) >>> 10;
    p_b_cb <= (PW'(cb1) * K_B_CB) >>> 10;
    y3     <= y2;
    mode3  <= mode2;
    r3     <= $signed(PW'(y2)) + p_r_cr;
    g3     <= $signed(PW'(y2)) - p_g_cb - p_g_cr;
    b3     <= $signed(PW'(y2)) + p_b_cb;
  end

  function automatic logic [DW-1:0] clamp(input logic signed [PW-1:0] v);
    if (v[PW-1]) return '0;
    if (v > PIX_MAX) return '1;
    return v[DW-1:0];
  endfunction

  function automatic logic beats(input logic [DW-1:0] t, input logic [DW-1:0] o1,
                                 input logic [DW-1:0] o2);
    logic signed [DDW-1:0] d1, d2;
    d1 = $signed(DDW'(t)) - $signed(DDW'(o1));
    d2 = $signed(DDW'(t)) - $signed(DDW'(o2));
    return (d1 > MARGIN) && (d2 > MARGIN);
  endfunction

  always_comb begin
    r_c   = clamp(r3);
    g_c   = clamp(g3);
    b_c   = clamp(b3);
    match = 1'b0;
    case (mode3)
      2'd0:    match = beats(g_c, r_c, b_c);
      2'd1:    match = beats(r_c, g_c, b_c);
      2'd2:    match = beats(b_c, r_c, g_c);
      default: match = 1'b0;
    endcase
    hit_nxt = v3 && match;
  end

  // sof3 and a valid pixel never coincide, so the frame swap never drops a hit.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      out_valid  <= 1'b0;
      hit        <= 1'b0;
      frame_done <= 1'b0;
      Y_out      <= '0;
      R_out      <= '0;
      G_out      <= '0;
      B_out      <= '0;
      frame_hits <= '0;
      hit_cnt    <= '0;
    end else begin
      out_valid  <= v3;
      hit        <= hit_nxt;
      frame_done <= sof3;
      if (v3) begin
        R_out <= r_c;
        G_out <= g_c;
        B_out <= b_c;
        Y_out <= hit_nxt ? {MARK, y3[DW-1:2]} : y3;
      end
      if (sof3) begin
        frame_hits <= hit_cnt;
        hit_cnt    <= '0;
      end else if (hit_nxt && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
    end
  end

`ifdef COLOR_DET_BBOX_EN
  logic [X_W-1:0] col_cnt, col1, col2, col3, bx_min, bx_max;
  logic [Y_W-1:0] row_cnt, row1, row2, row3, by_min, by_max;

  always_ff @(posedge PCLK) begin
    if (reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (sof) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      if (eol) col_cnt <= '0;
      else if (e_pix && (col_cnt != '1)) col_cnt <= col_cnt + X_W'(1);
      if (eol && (row_cnt != '1)) row_cnt <= row_cnt + Y_W'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    col1 <= col_cnt;
    col2 <= col1;
    col3 <= col2;
    row1 <= row_cnt;
    row2 <= row1;
    row3 <= row2;
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      bx_min     <= '1;
      bx_max     <= '0;
      by_min     <= '1;
      by_max     <= '0;
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
      bbox_valid <= 1'b0;
    end else if (sof3) begin
      bbox_x_min <= bx_min;
      bbox_x_max <= bx_max;
      bbox_y_min <= by_min;
      bbox_y_max <= by_max;
      bbox_valid <= (hit_cnt != '0);
      bx_min     <= '1;
      bx_max     <= '0;
      by_min     <= '1;
      by_max     <= '0;
    end else if (hit_nxt) begin
      if (col3 < bx_min) bx_min <= col3;
      if (col3 > bx_max) bx_max <= col3;
      if (row3 < by_min) by_min <= row3;
      if (row3 > by_max) by_max <= row3;
    end
  end
`else
  logic unused_eol;
  assign unused_eol = eol;
`endif

endmodule

// File: tb/tb_color_detector_pipe.sv
// Scoreboard bench: three instances (THRESH 70/254/253) share one directed stimulus stream.
// Expected pixels and frame counts are queued at issue time and popped by the output monitor.
module tb_color_detector_pipe;
  localparam int DW    = 8;
  localparam int CNT_W = 20;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  logic          PCLK  = 1'b0;
  logic          reset = 1'b1;
  logic          e_pix = 1'b0;
  logic          sof   = 1'b0;
  logic          eol   = 1'b0;
  logic [1:0]    mode  = 2'd0;
  logic [DW-1:0] Y     = '0;
  logic [DW-1:0] Cb    = '0;
  logic [DW-1:0] Cr    = '0;

  logic             ov [3];
  logic             ht [3];
  logic             fd [3];
  logic [DW-1:0]    yo [3];
  logic [DW-1:0]    ro [3];
  logic [DW-1:0]    go [3];
  logic [DW-1:0]    bo [3];
  logic [CNT_W-1:0] fh [3];
`ifdef COLOR_DET_BBOX_EN
  logic [X_W-1:0] bxl [3];
  logic [X_W-1:0] bxh [3];
  logic [Y_W-1:0] byl [3];
  logic [Y_W-1:0] byh [3];
  logic           bv  [3];
`endif

  always #5 PCLK = ~PCLK;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int TH = (i == 0) ? 70 : (i == 1) ? 254 : 253;
    color_detector_pipe #(.DW(DW), .THRESH(TH), .MARK(2'b11), .CNT_W(CNT_W),
                          .X_W(X_W), .Y_W(Y_W)) u_dut (
      .PCLK       (PCLK),
      .reset      (reset),
      .e_pix      (e_pix),
      .sof        (sof),
      .eol        (eol),
      .mode       (mode),
      .Y          (Y),
      .Cb         (Cb),
      .Cr         (Cr),
      .out_valid  (ov[i]),
      .hit        (ht[i]),
      .Y_out      (yo[i]),
      .R_out      (ro[i]),
      .G_out      (go[i]),
      .B_out      (bo[i]),
      .frame_hits (fh[i]),
      .frame_done (fd[i])
`ifdef COLOR_DET_BBOX_EN
      ,
      .bbox_x_min (bxl[i]),
      .bbox_x_max (bxh[i]),
      .bbox_y_min (byl[i]),
      .bbox_y_max (byh[i]),
      .bbox_valid (bv[i])
`endif
    );
  end

  // h[i] is the expected hit for instance i (THRESH 70, 254, 253)
  typedef struct {
    logic [2:0]    h;
    logic [DW-1:0] y, r, g, b;
  } pix_t;

  typedef struct {
    logic [2:0][CNT_W-1:0] n;
    bit                    chk_box;
    logic [X_W-1:0]        x0, x1;
    logic [Y_W-1:0]        y0, y1;
  } frm_t;

  pix_t pq [$];
  frm_t fq [$];

  int nchk = 0;
  int npass = 0;
  bit prev_rst = 1'b1;
  bit end_chk = 1'b0;
  bit end_done = 1'b0;
  logic [DW-1:0] last_y [3] = '{default: '0};
  logic [DW-1:0] last_r = '0, last_g = '0, last_b = '0;

  function automatic logic [DW-1:0] marked(input logic [DW-1:0] yv, input logic h);
    logic [DW-1:0] m;
    m = {2'b11, yv[DW-1:2]};
    return h ? m : yv;
  endfunction

  task automatic check(input bit ok, input string msg);
    nchk++;
    if (ok) npass++;
    else $display("FAIL %s", msg);
  endtask

  always @(negedge PCLK) begin
    pix_t p;
    frm_t f;
    if (prev_rst) begin
      for (int i = 0; i < 3; i++) begin
        check(ov[i] === 1'b0 && ht[i] === 1'b0 && fd[i] === 1'b0 && yo[i] === '0 &&
              ro[i] === '0 && go[i] === '0 && bo[i] === '0 && fh[i] === '0,
              $sformatf("reset_state inst%0d got v=%b hit=%b done=%b y=%h rgb=%0d/%0d/%0d hits=%0d, want all 0",
                        i, ov[i], ht[i], fd[i], yo[i], ro[i], go[i], bo[i], fh[i]));
        last_y[i] = '0;
      end
      last_r = '0;
      last_g = '0;
      last_b = '0;
    end else begin
      if (ov[0] === 1'b1) begin
        if (pq.size() == 0) begin
          check(1'b0, $sformatf("unexpected_pixel got out_valid=1 y=%h, want no output", yo[0]));
        end else begin
          p = pq.pop_front();
          for (int i = 0; i < 3; i++) begin
            check(ov[i] === 1'b1 && ht[i] === p.h[i] && yo[i] === marked(p.y, p.h[i]) &&
                  ro[i] === p.r && go[i] === p.g && bo[i] === p.b,
                  $sformatf("pixel inst%0d got v=%b hit=%b y=%h rgb=%0d/%0d/%0d, want v=1 hit=%b y=%h rgb=%0d/%0d/%0d",
                            i, ov[i], ht[i], yo[i], ro[i], go[i], bo[i],
                            p.h[i], marked(p.y, p.h[i]), p.r, p.g, p.b));
            last_y[i] = marked(p.y, p.h[i]);
          end
          last_r = p.r;
          last_g = p.g;
          last_b = p.b;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          check(ov[i] === 1'b0 && ht[i] === 1'b0 && yo[i] === last_y[i] &&
                ro[i] === last_r && go[i] === last_g && bo[i] === last_b,
                $sformatf("idle_hold inst%0d got v=%b hit=%b y=%h rgb=%0d/%0d/%0d, want v=0 hit=0 y=%h rgb=%0d/%0d/%0d",
                          i, ov[i], ht[i], yo[i], ro[i], go[i], bo[i],
                          last_y[i], last_r, last_g, last_b));
        end
      end
      if (fd[0] === 1'b1) begin
        if (fq.size() == 0) begin
          check(1'b0, $sformatf("unexpected_frame_done got frame_hits=%0d, want no pulse", fh[0]));
        end else begin
          f = fq.pop_front();
          for (int i = 0; i < 3; i++)
            check(fd[i] === 1'b1 && fh[i] === f.n[i],
                  $sformatf("frame_hits inst%0d got done=%b hits=%0d, want done=1 hits=%0d",
                            i, fd[i], fh[i], f.n[i]));
`ifdef COLOR_DET_BBOX_EN
          check(bv[0] === (f.n[0] != '0),
                $sformatf("bbox_valid got %b, want %b", bv[0], (f.n[0] != '0)));
          if (f.chk_box)
            check(bxl[0] === f.x0 && bxh[0] === f.x1 && byl[0] === f.y0 && byh[0] === f.y1,
                  $sformatf("bbox got x=%0d..%0d y=%0d..%0d, want x=%0d..%0d y=%0d..%0d",
                            bxl[0], bxh[0], byl[0], byh[0], f.x0, f.x1, f.y0, f.y1));
`endif
        end
      end
    end
    if (end_chk && !end_done) begin
      check(pq.size() == 0, $sformatf("pixels_drained got %0d outstanding, want 0", pq.size()));
      check(fq.size() == 0, $sformatf("frames_drained got %0d outstanding, want 0", fq.size()));
      end_done = 1'b1;
    end
    prev_rst = reset;
  end

  task automatic cyc(input logic ep, input logic sf, input logic el, input logic [1:0] m,
                     input logic [DW-1:0] yv, input logic [DW-1:0] cbv, input logic [DW-1:0] crv);
    @(posedge PCLK);
    #1;
    e_pix = ep;
    sof   = sf;
    eol   = el;
    mode  = m;
    Y     = yv;
    Cb    = cbv;
    Cr    = crv;
  endtask

  task automatic px(input logic [1:0] m, input logic [DW-1:0] yv, input logic [DW-1:0] cbv,
                    input logic [DW-1:0] crv, input logic [DW-1:0] r, input logic [DW-1:0] g,
                    input logic [DW-1:0] b, input logic [2:0] h, input bit push);
    pix_t p;
    cyc(1'b1, 1'b0, 1'b0, m, yv, cbv, crv);
    p.h = h;
    p.y = yv;
    p.r = r;
    p.g = g;
    p.b = b;
    if (push) pq.push_back(p);
  endtask

  task automatic green(input logic [1:0] m, input logic [2:0] h, input bit push);
    px(m, 8'd150, 8'd44, 8'd21, 8'd0, 8'd255, 8'd1, h, push);
  endtask

  task automatic gray();
    px(2'd0, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 3'b000, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0);
  endtask

  task automatic do_eol();
    cyc(1'b0, 1'b0, 1'b1, 2'd0, '0, '0, '0);
  endtask

  task automatic do_sof(input int n0, input int n1, input int n2, input bit box,
                        input int x0, input int x1, input int y0, input int y1);
    frm_t f;
    cyc(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, '0);
    f.n[0]    = CNT_W'(n0);
    f.n[1]    = CNT_W'(n1);
    f.n[2]    = CNT_W'(n2);
    f.chk_box = box;
    f.x0      = X_W'(x0);
    f.x1      = X_W'(x1);
    f.y0      = Y_W'(y0);
    f.y1      = Y_W'(y1);
    fq.push_back(f);
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    #1 reset = 1'b0;

    // Conversion vectors, mode changing every pixel
    green(2'd0, 3'b101, 1'b1);
    px(2'd0, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 3'b000, 1'b1);
    px(2'd3, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 3'b000, 1'b1);
    px(2'd1, 8'd255, 8'd128, 8'd255, 8'd255, 8'd165, 8'd255, 3'b000, 1'b1);
    px(2'd1, 8'd100, 8'd128, 8'd255, 8'd255, 8'd10,  8'd100, 3'b001, 1'b1);
    px(2'd2, 8'd100, 8'd255, 8'd128, 8'd100, 8'd57,  8'd255, 3'b001, 1'b1);
    green(2'd3, 3'b000, 1'b1);
    green(2'd2, 3'b000, 1'b1);
    idle(2);
    do_sof(3, 0, 1, 1'b0, 0, 0, 0, 0);

    // 5 green, 3 gray, 2 green, sof right after the last pixel
    repeat (5) green(2'd0, 3'b101, 1'b1);
    repeat (3) gray();
    repeat (2) green(2'd0, 3'b101, 1'b1);
    do_sof(7, 0, 7, 1'b0, 0, 0, 0, 0);
    idle(4);
    do_sof(0, 0, 0, 1'b0, 0, 0, 0, 0);

    // Greens at (x=3,y=0) and (x=7,y=2)
    repeat (3) gray();
    green(2'd0, 3'b101, 1'b1);
    do_eol();
    do_eol();
    repeat (7) gray();
    green(2'd0, 3'b101, 1'b1);
    idle(1);
    do_sof(2, 0, 2, 1'b1, 3, 7, 0, 2);
    idle(4);

    // One counted green, then a green discarded by reset one cycle after its e_pix
    green(2'd0, 3'b101, 1'b1);
    idle(5);
    green(2'd0, 3'b101, 1'b0);
    @(posedge PCLK);
    #1;
    e_pix = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 reset = 1'b0;
    idle(2);
    do_sof(0, 0, 0, 1'b0, 0, 0, 0, 0);
    idle(6);

    end_chk = 1'b1;
    repeat (2) @(negedge PCLK);
    #1;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
